smg_scan_module: RTL
====================

Name: smg_scan_module

Overview:
- Time-multiplexed scan controller for a multi-digit seven-segment display.
- Holds a double-buffered digit store written by game logic. Feeds one 4-bit code at a time to smg_encode_module, which is registered with 1-cycle latency.
- Drives the active-low digit selects, with dead time between digits to prevent ghosting.
- Sits between the score/level logic and the encoder/pins.

Parameters:
- DIGITS, 4, number of digits scanned; 2..8.
- SCAN_DIV, 50000, clocks per digit slot; must be greater than DEAD_CYC.
- DEAD_CYC, 2, clocks at the start of each slot with all selects off; must be at least 1, which hides encoder latency.
- CNT_W, 16, width of slot counter; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write strobe for shadow buffer
- wr_idx  input  3  digit index; 0 is rightmost; index >= DIGITS is ignored
- wr_data  input  4  encoder code; 0-9 digits, 10-14 L/E/V/A/D, 15 dash
- wr_ready  output  1  write accepted this cycle when high
- blank_en  input  1  force display dark
- Number_Data  output  4  code to smg_encode_module.Number_Data
- SMG_Sel  output  DIGITS  digit enables, active-low; bit i is digit i
- frame_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset, asynchronous, applies immediately mid-operation:
  - all shadow and active buffer entries = 4'd15
  - Number_Data = 4'd15, SMG_Sel = all ones, frame_done = 0, wr_ready = 1
  - slot counter = 0, scan index = 0, state = DEAD
- Slot counter:
  - increments every clock, 0..SCAN_DIV-1, then wraps to 0
  - wrap = slot boundary
- States:
  - DEAD: counter < DEAD_CYC; SMG_Sel all ones.
  - DRIVE: counter >= DEAD_CYC; SMG_Sel drives the current digit.
  - DEAD goes to DRIVE when the counter reaches DEAD_CYC. DRIVE goes to DEAD at the slot boundary.
- At each slot boundary, on the edge where the counter goes to 0:
  - scan index advances modulo DIGITS
  - Number_Data <= active[new index], registered
  - encoder output is valid 1 clock later, still inside DEAD
- SMG_Sel in DRIVE:
  - SMG_Sel is registered.
  - It is all ones except bit[index] = 0.
  - It goes low on the edge where the counter reaches DEAD_CYC and returns all ones at the boundary.
- blank_en:
  - When high, SMG_Sel is all ones from the next edge.
  - Scanning, Number_Data and buffers continue unaffected.
  - Deasserting resumes at the current slot phase.
- Writes:
  - A write is accepted when wr_en and wr_ready are both high.
  - shadow[wr_idx] <= wr_data.
  - Out-of-range idx: no effect, still counts as accepted.
- Frame boundary: the slot boundary where the index wraps from DIGITS-1 to 0.
  - In the preceding cycle, i.e. the last cycle of the last slot: frame_done = 1 and wr_ready = 0.
  - On that cycle's edge, active <= shadow for all entries, as one atomic copy.
  - A write presented in that cycle is not accepted and is dropped; the writer must hold it.
  - The new frame's digit 0 uses the copied data. No tearing within a frame.
- Simultaneous blank_en and frame boundary: the copy still occurs.

Optional Feature:
- Macro SMG_ZERO_SUPPRESS_EN.
- Defined: leading zeros are suppressed.
  - For digit i > 0, SMG_Sel[i] stays 1 in DRIVE when active[i] and all active[j] for j > i are 4'd0.
  - Digit 0 is always shown.
  - Evaluation uses the active buffer.
- Undefined: every digit is driven regardless of value.

Test Plan (DIGITS=4, SCAN_DIV=8, DEAD_CYC=2):
1. Release rst -> Number_Data=15, SMG_Sel=1111 for counts 0-1, then 1110 for counts 2-7; next slot 1101; frame_done first pulses at clock 31.
2. Mid-frame write idx0..3 = 1,2,3,4 -> the current frame still shows 15 on all digits. The next frame gives Number_Data 1,2,3,4 with SMG_Sel 1110,1101,1011,0111 in DRIVE.
3. wr_en with idx2=9 in the frame_done cycle -> wr_ready=0, write dropped, digit 2 is unchanged in the next frame. Re-issue on the next cycle -> accepted and shown the frame after.
4. blank_en=1 for 20 clocks -> SMG_Sel=1111 from the next edge, Number_Data keeps stepping; after release, selects resume at the correct slot phase.
5. Assert rst at counter=5 of digit 2 -> outputs return to reset values in the same cycle without waiting for clk; buffers read 15 on the next frame.
6. SMG_ZERO_SUPPRESS_EN, active = {idx3..0} = 0,0,7,0 -> digits 3 and 2 never go low; digits 1 and 0 are driven (0 shown). With the macro undefined, all four are driven.

Source files
------------

// File: rtl/smg_scan_module_if.sv
// Bus between game logic / pin driver and the seven-segment scan controller.
// The master side writes digit codes and controls blanking; the slave is the scanner.
interface smg_scan_module_if #(
    parameter int DIGITS = 4
);
    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [3:0]        wr_data;
    logic              wr_ready;
    logic              blank_en;
    logic [3:0]        Number_Data;
    logic [DIGITS-1:0] SMG_Sel;
    logic              frame_done;

    modport master (
        output wr_en, wr_idx, wr_data, blank_en,
        input  wr_ready, Number_Data, SMG_Sel, frame_done
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, blank_en,
        output wr_ready, Number_Data, SMG_Sel, frame_done
    );
endinterface

// File: rtl/smg_scan_module.sv
// Time-multiplexed seven-segment scan controller with a double-buffered digit store.
// Optional build macro SMG_ZERO_SUPPRESS_EN blanks leading zero digits.
module smg_scan_module #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    smg_scan_module_if.slave bus
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

    typedef enum logic {ST_DEAD, ST_DRIVE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        num_q, num_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [3:0]        shadow_q [DIGITS];
    logic [3:0]        shadow_d [DIGITS];
    logic [3:0]        active_q [DIGITS];
    logic [3:0]        active_d [DIGITS];
    logic [DIGITS-1:0] show;

    logic slot_end;
    logic frame_end;
    logic wr_ready;

    assign slot_end  = (cnt_q == LAST_CNT);
    assign frame_end = slot_end && (idx_q == LAST_IDX);
    // The copy cycle refuses writes so the shadow is stable while it is transferred.
    assign wr_ready  = !frame_end;

    assign bus.wr_ready    = wr_ready;
    assign bus.frame_done  = frame_end;
    assign bus.Number_Data = num_q;
    assign bus.SMG_Sel     = sel_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) state_q <= ST_DEAD;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_DEAD:  if (cnt_q == DEAD_LAST) state_d = ST_DRIVE;
            ST_DRIVE: if (slot_end)           state_d = ST_DEAD;
            default:                          state_d = ST_DEAD;
        endcase
    end

    // Counter, scan index and buffers.
    always_comb begin
        // NOTE: every comb output gets a default first, otherwise a latch is inferred.
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = frame_end ? shadow_q : active_q;
        if (slot_end) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        if (bus.wr_en && wr_ready) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (bus.wr_idx == 3'(i)) shadow_d[i] = bus.wr_data;
            end
        end
    end

    // Which digits are allowed to light in DRIVE.
`ifdef SMG_ZERO_SUPPRESS_EN
    always_comb begin
        logic nonzero_above;
        nonzero_above = 1'b0;
        show          = '1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            nonzero_above = nonzero_above || (active_q[i] != 4'd0);
            show[i]       = nonzero_above;
        end
    end
`else
    assign show = '1;
`endif

    // Output logic: code to the encoder and registered active-low selects.
    always_comb begin
        num_d = num_q;
        sel_d = '1;
        if (slot_end) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_d == IDX_W'(i)) num_d = active_d[i];
            end
        end
        if (state_d == ST_DRIVE && !bus.blank_en) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_d == IDX_W'(i) && show[i]) sel_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            num_q    <= 4'd15;
            sel_q    <= '1;
            // NOTE: the digit store is reset on purpose so a fresh display shows dashes, not garbage.
            shadow_q <= '{default: 4'd15};
            active_q <= '{default: 4'd15};
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end
endmodule
